// File: rtl/inference_sequencer_pkg.sv
// Shared constants and FSM state encoding for the frame-level inference sequencer.
package inference_sequencer_pkg;

    localparam int FFN_OUT_BITWIDTH = 31;
    localparam int NUM_CLASSES      = 10;
    localparam int SCORE_W          = FFN_OUT_BITWIDTH + 1;
    localparam int IDX_W            = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_FFN    = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/inference_sequencer_seq_argmax.sv
// Serial argmax: one class compared per step; ties keep the lower index.
module inference_sequencer_seq_argmax #(
    parameter int NUM_CLASSES = inference_sequencer_pkg::NUM_CLASSES,
    parameter int SCORE_W     = inference_sequencer_pkg::SCORE_W,
    parameter int IDX_W       = inference_sequencer_pkg::IDX_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic                         step_i,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_i,
    output logic [IDX_W-1:0]             best_idx_o,
    output logic [SCORE_W-1:0]           best_score_o,
    output logic                         last_o
);
    import inference_sequencer_pkg::*;

    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;
    logic signed [SCORE_W-1:0] best_score_q, best_score_d;
    logic signed [SCORE_W-1:0] cand;

    assign last_o = (ptr_q == IDX_W'(NUM_CLASSES - 1));

    always_comb begin
        cand         = scores_i[int'(ptr_q)*SCORE_W +: SCORE_W];
        ptr_d        = ptr_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        if (load_i) begin
            best_score_d = scores_i[SCORE_W-1:0];
            best_idx_d   = '0;
            ptr_d        = IDX_W'(1);
        end else if (step_i) begin
            if (cand > best_score_q) begin
                best_score_d = cand;
                best_idx_d   = ptr_q;
            end
            // Parking on the last class keeps the score mux in range once done.
            if (!last_o) begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
        end
    end

    assign best_idx_o   = best_idx_q;
    assign best_score_o = best_score_q;

endmodule

// File: rtl/inference_sequencer.sv
// Frame scheduler: CONV -> FFN -> serial ARGMAX, with a per-phase watchdog.
module inference_sequencer #(
    parameter int NUM_CLASSES    = inference_sequencer_pkg::NUM_CLASSES,
    parameter int SCORE_W        = inference_sequencer_pkg::SCORE_W,
    parameter int IDX_W          = inference_sequencer_pkg::IDX_W,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 21
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           en_i,
    input  logic                           buffer_rdy_i,
    input  logic                           fm_buffer_full_i,
    input  logic                           product_rdy_i,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_i,
    output logic                           conv_start_o,
    output logic                           mm_start_o,
    output logic                           busy_o,
    output logic                           result_valid_o,
    output logic [IDX_W-1:0]               class_idx_o,
    output logic [SCORE_W-1:0]             class_score_o,
    output logic [15:0]                    frame_count_o,
    output logic                           timeout_err_o
);
    import inference_sequencer_pkg::*;

    seq_state_e         state_q;
    logic [TO_W-1:0]    wd_q;
    logic               fm_q, prod_q;
    logic               conv_start_q, mm_start_q, result_valid_q, timeout_err_q;
    logic [IDX_W-1:0]   class_idx_q;
    logic [SCORE_W-1:0] class_score_q;
    logic [15:0]        frame_count_q;

    logic               fm_rise, prod_rise, wd_expired;
    logic               am_load, am_step, am_last;
    logic [IDX_W-1:0]   am_idx;
    logic [SCORE_W-1:0] am_score;

    // Edge copies reset high so a level already asserted at reset release is not an edge.
    assign fm_rise    = fm_buffer_full_i & ~fm_q;
    assign prod_rise  = product_rdy_i & ~prod_q;
    assign wd_expired = (wd_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign am_load    = (state_q == ST_FFN) && prod_rise;
    assign am_step    = (state_q == ST_ARGMAX);

    inference_sequencer_seq_argmax #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W),
        .IDX_W       (IDX_W)
    ) u_argmax (
        .clk_i        (clock_i),
        .rst_i        (reset_i),
        .load_i       (am_load),
        .step_i       (am_step),
        .scores_i     (scores_i),
        .best_idx_o   (am_idx),
        .best_score_o (am_score),
        .last_o       (am_last)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            wd_q           <= '0;
            fm_q           <= 1'b1;
            prod_q         <= 1'b1;
            conv_start_q   <= 1'b0;
            mm_start_q     <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            class_idx_q    <= '0;
            class_score_q  <= '0;
            frame_count_q  <= '0;
        end else begin
            fm_q           <= fm_buffer_full_i;
            prod_q         <= product_rdy_i;
            conv_start_q   <= 1'b0;
            mm_start_q     <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en_i && buffer_rdy_i) begin
                        conv_start_q <= 1'b1;
                        wd_q         <= '0;
                        state_q      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    // A coincident product_rdy edge is dropped here; its copy is still updated.
                    if (fm_rise) begin
                        mm_start_q <= 1'b1;
                        wd_q       <= '0;
                        state_q    <= ST_FFN;
                    end else if (wd_expired) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_FFN: begin
                    if (prod_rise) begin
                        state_q <= ST_ARGMAX;
                    end else if (wd_expired) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_ARGMAX: begin
                    if (am_last) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    class_idx_q    <= am_idx;
                    class_score_q  <= am_score;
                    result_valid_q <= 1'b1;
                    frame_count_q  <= frame_count_q + 1'b1;
                    timeout_err_q  <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv_start_o   = conv_start_q;
    assign mm_start_o     = mm_start_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign result_valid_o = result_valid_q;
    assign class_idx_o    = class_idx_q;
    assign class_score_o  = class_score_q;
    assign frame_count_o  = frame_count_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed + randomized frames against a plain-arithmetic argmax/frame-count model.
module tb_inference_sequencer;

    localparam int NC = 10;
    localparam int SW = 32;
    localparam int IW = 4;
    localparam int TO = 64;

    logic             clock = 1'b0;
    logic             reset, en, buffer_rdy, fm_buffer_full, product_rdy;
    logic [NC*SW-1:0] scores;
    logic             conv_start, mm_start, busy, result_valid, timeout_err;
    logic [IW-1:0]    class_idx;
    logic [SW-1:0]    class_score;
    logic [15:0]      frame_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_conv   = 0;
    int n_mm     = 0;
    int n_rv     = 0;

    logic signed [SW-1:0] sc [NC];
    logic [IW-1:0]        exp_idx   = '0;
    logic [SW-1:0]        exp_score = '0;
    logic [15:0]          exp_fc    = '0;

    inference_sequencer #(
        .NUM_CLASSES    (NC),
        .SCORE_W        (SW),
        .IDX_W          (IW),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (7)
    ) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .en_i             (en),
        .buffer_rdy_i     (buffer_rdy),
        .fm_buffer_full_i (fm_buffer_full),
        .product_rdy_i    (product_rdy),
        .scores_i         (scores),
        .conv_start_o     (conv_start),
        .mm_start_o       (mm_start),
        .busy_o           (busy),
        .result_valid_o   (result_valid),
        .class_idx_o      (class_idx),
        .class_score_o    (class_score),
        .frame_count_o    (frame_count),
        .timeout_err_o    (timeout_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (conv_start)   n_conv++;
        if (mm_start)     n_mm++;
        if (result_valid) n_rv++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_scores();
        int best;
        best = 0;
        for (int i = 0; i < NC; i++) begin
            scores[i*SW +: SW] = sc[i];
            if (sc[i] > sc[best]) best = i;
        end
        exp_idx   = IW'(best);
        exp_score = sc[best];
    endtask

    task automatic rand_scores();
        for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 1) == 1) sc[i] = int'($urandom_range(0, 6)) - 3;
            else                           sc[i] = $urandom;
        end
        load_scores();
    endtask

    task automatic start_frame(input string tag);
        int k;
        k = 0;
        en         = 1'b1;
        buffer_rdy = 1'b1;
        do begin
            tick(1);
            k++;
        end while (!conv_start && k < 10);
        check({tag, "_conv_start"}, conv_start, 1'b1);
    endtask

    task automatic conv_phase(input int d);
        tick(d);
        fm_buffer_full = 1'b1;
        tick(2);
        fm_buffer_full = 1'b0;
    endtask

    task automatic ffn_finish(input string tag, input int d);
        int k0, k;
        tick(d);
        product_rdy = 1'b1;
        k0 = cyc;
        tick(2);
        product_rdy = 1'b0;
        k = 0;
        while (!result_valid && k < 30) begin
            tick(1);
            k++;
        end
        exp_fc = exp_fc + 16'd1;
        check({tag, "_latency"}, cyc - k0, 11);
        check({tag, "_idx"}, class_idx, exp_idx);
        check({tag, "_score"}, class_score, exp_score);
        check({tag, "_frame_count"}, frame_count, exp_fc);
        check({tag, "_timeout_clr"}, timeout_err, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_conv_start"}, conv_start, 1'b0);
        check({tag, "_mm_start"}, mm_start, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_result_valid"}, result_valid, 1'b0);
        check({tag, "_class_idx"}, class_idx, '0);
        check({tag, "_class_score"}, class_score, '0);
        check({tag, "_frame_count"}, frame_count, '0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        int c0, mm0, rv0, conv0, k, k0, r;
        logic [IW-1:0] held_idx;
        logic [SW-1:0] held_score;

        reset = 1'b1; en = 1'b0; buffer_rdy = 1'b0;
        fm_buffer_full = 1'b0; product_rdy = 1'b0; scores = '0;
        #3;
        check_all_zero("reset");
        tick(2);
        reset = 1'b0;
        tick(2);

        // Nominal frame, tie between classes 2 and 3
        sc = '{5, -3, 17, 17, 2, 0, -100, 9, 16, 1};
        load_scores();
        start_frame("nom");
        buffer_rdy = 1'b0;
        conv_phase(50);
        ffn_finish("nom", 20);
        check("nom_idx_const", class_idx, 4'd2);
        check("nom_score_const", class_score, 32'd17);
        check("nom_conv_count", n_conv, 1);
        check("nom_mm_count", n_mm, 1);
        tick(3);

        // All negative
        for (int i = 0; i < NC; i++) sc[i] = -50;
        sc[9] = -1;
        load_scores();
        start_frame("neg");
        buffer_rdy = 1'b0;
        conv_phase(7);
        ffn_finish("neg", 4);
        check("neg_score_const", class_score, 32'hFFFF_FFFF);
        tick(3);

        // Watchdog expiry in CONV
        held_idx = class_idx; held_score = class_score;
        mm0 = n_mm;
        start_frame("wd");
        buffer_rdy = 1'b0;
        c0 = cyc;
        k = 0;
        while (!timeout_err && k < 100) begin
            tick(1);
            k++;
        end
        check("wd_latency", cyc - c0, TO);
        check("wd_timeout_err", timeout_err, 1'b1);
        check("wd_busy", busy, 1'b0);
        check("wd_no_mm_start", n_mm, mm0);
        check("wd_idx_held", class_idx, held_idx);
        check("wd_score_held", class_score, held_score);
        check("wd_fc_held", frame_count, exp_fc);
        rand_scores();
        start_frame("wd_recover");
        buffer_rdy = 1'b0;
        conv_phase(5);
        ffn_finish("wd_recover", 5);
        tick(2);

        // Spurious product_rdy in CONV, then colliding edges
        rand_scores();
        mm0 = n_mm; rv0 = n_rv;
        start_frame("spur");
        buffer_rdy = 1'b0;
        tick(5);
        product_rdy = 1'b1; tick(3); product_rdy = 1'b0; tick(3);
        product_rdy = 1'b1; tick(1); product_rdy = 1'b0; tick(4);
        check("spur_still_conv", n_mm, mm0);
        fm_buffer_full = 1'b1;
        product_rdy    = 1'b1;
        tick(20);
        fm_buffer_full = 1'b0;
        tick(2);
        check("collide_mm_once", n_mm, mm0 + 1);
        check("collide_no_result", n_rv, rv0);
        check("collide_busy", busy, 1'b1);
        product_rdy = 1'b0;
        tick(2);
        ffn_finish("collide", 3);
        tick(2);

        // Randomized frames; en sometimes dropped mid-frame
        for (int f = 0; f < 8; f++) begin
            rand_scores();
            conv0 = n_conv;
            start_frame("rand");
            buffer_rdy = 1'b0;
            if ($urandom_range(0, 1) == 1) en = 1'b0;
            conv_phase(int'($urandom_range(1, 40)));
            ffn_finish("rand", int'($urandom_range(1, 40)));
            check("rand_one_conv", n_conv, conv0 + 1);
            tick(int'($urandom_range(1, 4)));
        end

        // Frame counter wrap with back-to-back start
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        exp_fc = 16'hFFFF;
        check("wrap_preload", frame_count, 16'hFFFF);
        rand_scores();
        start_frame("wrap");
        conv_phase(6);
        ffn_finish("wrap", 6);
        r = cyc;
        check("b2b_no_early_start", conv_start, 1'b0);
        tick(1);
        check("b2b_start_next", conv_start, 1'b1);
        check("b2b_gap", cyc - r, 1);

        // Reset in the middle of ARGMAX (ptr = 5)
        conv_phase(5);
        tick(3);
        product_rdy = 1'b1;
        k0 = cyc;
        tick(5);
        check("argmax_in_progress", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        product_rdy = 1'b0;
        tick(1);
        check("mid_reset_hold_no_start", conv_start, 1'b0);
        #2;
        reset = 1'b0;
        exp_fc = '0;
        tick(1);
        check("post_reset_start", conv_start, 1'b1);
        rand_scores();
        buffer_rdy = 1'b0;
        conv_phase(4);
        ffn_finish("post_reset", 4);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Frame-level scheduler for the CNN inference pipeline.
- Sequences one frame through three phases: convolution/pooling, feed-forward matrix multiply, then a serial argmax over the class sums.
- Sits beside the window, mult-adder, feature-map and matrix-multiply controllers and drives their start strobes. It latches the winning class for the display/hex decode.
- A per-phase watchdog recovers from a stalled stage.

Parameters:
- NUM_CLASSES, 10, number of network output sums.
- SCORE_W, 32, width of each signed class sum (FFN_OUT_BITWIDTH+1).
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASSES.
- TIMEOUT_CYCLES, 1048576, maximum cycles allowed in the CONV or FFN phase.
- TO_W, 21, watchdog counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  allow a new frame to start; sampled only in IDLE.
- buffer_rdy  in  1  level, shifting window buffer full.
- fm_buffer_full  in  1  level, feature-map RAMs complete.
- product_rdy  in  1  level, matrix multiply sums valid.
- scores  in  NUM_CLASSES*SCORE_W  packed signed sums; class i occupies bits [i*SCORE_W +: SCORE_W].
- conv_start  out  1  one-cycle start pulse to mult_adder_ctrl.
- mm_start  out  1  one-cycle start pulse to np_matrix_mult_ctrl.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  one-cycle pulse when a new result is latched.
- class_idx  out  IDX_W  latched winning class.
- class_score  out  SCORE_W  latched winning sum.
- frame_count  out  16  completed frames; wraps at 65535 -> 0.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by reset or by the next successful result.

Behaviour:
- Reset value of all outputs is 0; state is IDLE; argmax registers are 0.
- Rising edges of fm_buffer_full and product_rdy are detected with one registered copy of each. The registered copies reset to 1, so a level already high at reset release is not treated as an edge.
- States and transitions:
  - IDLE: if en && buffer_rdy, then assert conv_start for one cycle, clear the watchdog, and go to CONV.
  - CONV: the watchdog increments each cycle.
    - On a rising edge of fm_buffer_full, assert mm_start for one cycle, clear the watchdog, and go to FFN.
    - If the watchdog reaches TIMEOUT_CYCLES-1, set timeout_err and go to IDLE.
  - FFN: on a rising edge of product_rdy, load best_score=scores[0], best_idx=0, ptr=1, and go to ARGMAX. The watchdog applies as in CONV.
  - ARGMAX: one class per cycle. If scores[ptr] > best_score (signed compare), update best_score and best_idx. Ties keep the lower index. ptr increments.
    - After ptr=NUM_CLASSES-1 has been evaluated, go to DONE.
    - scores are sampled live, so the matrix-multiply sums must stay stable until DONE; np_matrix_mult holds them while en is low.
  - DONE: latch class_idx/class_score, pulse result_valid, increment frame_count, clear timeout_err, and go to IDLE.
- Latency: a product_rdy edge in cycle t produces result_valid in cycle t+NUM_CLASSES+1. For NUM_CLASSES=10, that is t+11.
- Edge collision: if rising edges of fm_buffer_full and product_rdy occur in the same cycle while in CONV, only fm_buffer_full is acted on. The product_rdy edge is discarded.
- Edges arriving in a state that does not expect them are ignored.
- en deasserted mid-frame does not abort; the frame completes, and en gates only the next start.
- buffer_rdy held high with en high starts back-to-back frames: conv_start is re-issued in the cycle after DONE.
- Reset mid-operation returns immediately to IDLE with no start pulses. The previous result is lost (outputs return to 0).
- class_idx/class_score hold their value between frames and on timeout.

Decomposition:
- Shared package: state encoding (IDLE=0, CONV=1, FFN=2, ARGMAX=3, DONE=4, 3 bits), a NUM_CLASSES constant tied to the network params header, and a SCORE_W derived from FFN_OUT_BITWIDTH.
- One natural sub-module: seq_argmax. It holds the serial compare/update datapath (load, step, best_idx/best_score, last flag). The FSM and watchdog stay in the top level of the block.

Test Plan:
- Nominal frame:
  - Stimulus: en=1; buffer_rdy rises; fm_buffer_full rises 50 cycles later; product_rdy rises 20 cycles after that; scores = {0..9: 5,-3,17,17,2,0,-100,9,16,1}.
  - Required: one conv_start, one mm_start, result_valid 11 cycles after product_rdy, class_idx=2 (tie with class 3 resolves to the lower index), class_score=17, frame_count=1.
- All-negative scores:
  - Stimulus: all classes = -50 except class 9 = -1.
  - Required: class_idx=9, class_score=0xFFFFFFFF.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=64; fm_buffer_full never rises.
  - Required: timeout_err=1 exactly 64 cycles after conv_start, busy=0, no mm_start. A following good frame clears timeout_err.
- Spurious and colliding edges:
  - Stimulus: product_rdy pulses during CONV; separately, fm_buffer_full and product_rdy rise in the same cycle during CONV.
  - Required: no ARGMAX entry; the FFN transition occurs once; no result_valid until a later product_rdy edge.
- Async reset mid-ARGMAX:
  - Stimulus: assert reset at ptr=5.
  - Required: all outputs 0 immediately, state IDLE. With buffer_rdy still high and en=1, conv_start occurs on the first edge after release.
- Back-to-back and wrap:
  - Stimulus: frame_count preloaded via 65535 frames, or forced by the bench.
  - Required: the next frame yields frame_count=0. With en held high, conv_start follows DONE by exactly 1 cycle.
